// File: rtl/tt_accum_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tt_accum_pkg
// Purpose  : Shared definitions for the accumulator-bank tile: opcode
//            encodings, uio pin bit positions and the readback view type.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package tt_accum_pkg;

  // Command opcodes carried on uio_in[2:0]
  localparam logic [2:0] OP_NOP   = 3'b000;
  localparam logic [2:0] OP_LOAD  = 3'b001;
  localparam logic [2:0] OP_ADD   = 3'b010;
  localparam logic [2:0] OP_SUB   = 3'b011;
  localparam logic [2:0] OP_CLR   = 3'b100;
  localparam logic [2:0] OP_ADDS  = 3'b101;
  localparam logic [2:0] OP_SHL   = 3'b110;
  localparam logic [2:0] OP_FLAGS = 3'b111;

  // Bit positions within uio_in
  localparam int UIO_OP_LO  = 0;
  localparam int UIO_OP_HI  = 2;
  localparam int UIO_SEL_LO = 3;
  localparam int UIO_SEL_HI = 4;
  localparam int UIO_STB    = 5;
  localparam int UIO_BYTE   = 6;
  localparam int UIO_SAT    = 7;

  // What uo_out shows: an accumulator byte or the overflow flags
  typedef enum logic {
    VIEW_DATA  = 1'b0,
    VIEW_FLAGS = 1'b1
  } view_t;

endpackage : tt_accum_pkg
`default_nettype wire

// File: rtl/tt_strobe_sync.sv
`default_nettype none
// ============================================================================
// Module   : tt_strobe_sync
// Purpose  : Multi-flop synchroniser for the asynchronous command strobe,
//            followed by a rising-edge detector producing a one-cycle pulse.
// Ports    : clk      - clock
//            rst_n    - asynchronous active-low reset
//            i_strobe - raw strobe pin
//            o_pulse  - one-cycle pulse per synchronised rising edge
// Revision : 1.0 - initial release
// ============================================================================
module tt_strobe_sync
  import tt_accum_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_strobe,
  output logic o_pulse
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  // All flops reset to 1 so a strobe already high at reset release is seen
  // as a steady level, not a fresh rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '1;
      r_prev <= 1'b1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_strobe};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_pulse = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule : tt_strobe_sync
`default_nettype wire

// File: rtl/tt_um_accum_bank.sv
`default_nettype none
// ============================================================================
// Module   : tt_um_accum_bank
// Purpose  : Tile top holding a bank of NUM_ACC accumulators driven by
//            strobed 8-bit commands, with optional saturation, sticky
//            overflow flags and registered byte-wide readback.
// Ports    : clk     - clock
//            rst_n   - asynchronous active-low reset
//            ena     - tile enable (unused)
//            ui_in   - operand A
//            uio_in  - [2:0] opcode, [4:3] select, [5] strobe,
//                      [6] byte select, [7] saturate enable
//            uo_out  - registered readback byte
//            uio_out - constant 0
//            uio_oe  - constant 0 (uio pins are inputs)
// Revision : 1.0 - initial release
// ============================================================================
module tt_um_accum_bank
  import tt_accum_pkg::*;
#(
  parameter int ACC_W       = 16,
  parameter int NUM_ACC     = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  // Select bits beyond the bank size are dropped
  localparam logic [1:0] c_sel_mask = 2'(NUM_ACC - 1);

  logic [ACC_W-1:0]   r_acc [NUM_ACC];
  logic [NUM_ACC-1:0] r_ovf;
  view_t              r_view;
  logic [7:0]         r_uo;

  logic             w_fire;
  logic [2:0]       w_op;
  logic [1:0]       w_sel;
  logic             w_sat;
  logic [ACC_W-1:0] w_cur;
  logic [ACC_W-1:0] w_a_zx;
  logic [ACC_W-1:0] w_a_sx;
  logic [ACC_W:0]   w_sum;
  logic [ACC_W:0]   w_dif;
  logic [ACC_W-1:0] w_sadd;
  logic [ACC_W-1:0] w_next;
  logic             w_ovf;
  logic             w_clr_ovf;
  logic [ACC_W-1:0] w_hi_shift;
  logic [7:0]       w_flags;
  logic             w_unused;

  assign w_unused = ena;

  tt_strobe_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_strobe_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_strobe (uio_in[UIO_STB]),
    .o_pulse  (w_fire)
  );

  assign w_op  = uio_in[UIO_OP_HI:UIO_OP_LO];
  assign w_sel = uio_in[UIO_SEL_HI:UIO_SEL_LO] & c_sel_mask;
  assign w_sat = uio_in[UIO_SAT];

  // Currently selected accumulator: operand for execution and readback source
  always_comb begin
    w_cur = '0;
    for (int i = 0; i < NUM_ACC; i++) begin
      if (w_sel == 2'(i)) w_cur = r_acc[i];
    end
  end

  assign w_a_zx = {{(ACC_W-8){1'b0}}, ui_in};
  assign w_a_sx = {{(ACC_W-8){ui_in[7]}}, ui_in};
  assign w_sum  = {1'b0, w_cur} + {1'b0, w_a_zx};
  assign w_dif  = {1'b0, w_cur} - {1'b0, w_a_zx};
  assign w_sadd = w_cur + w_a_sx;

  // Next value and overflow for the selected accumulator
  always_comb begin
    w_next    = w_cur;
    w_ovf     = 1'b0;
    w_clr_ovf = 1'b0;
    case (w_op)
      OP_LOAD: begin
        w_next    = w_a_zx;
        w_clr_ovf = 1'b1;
      end
      OP_ADD: begin
        w_ovf  = w_sum[ACC_W];
        w_next = (w_ovf && w_sat) ? '1 : w_sum[ACC_W-1:0];
      end
      OP_SUB: begin
        // Extra result bit holds the borrow
        w_ovf  = w_dif[ACC_W];
        w_next = (w_ovf && w_sat) ? '0 : w_dif[ACC_W-1:0];
      end
      OP_CLR: begin
        w_next    = '0;
        w_clr_ovf = 1'b1;
      end
      OP_ADDS: begin
        // Signed overflow: same operand signs, result sign flipped
        w_ovf = (w_cur[ACC_W-1] == ui_in[7]) && (w_sadd[ACC_W-1] != w_cur[ACC_W-1]);
        if (w_ovf && w_sat) begin
          w_next = ui_in[7] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        end else begin
          w_next = w_sadd;
        end
      end
      OP_SHL: begin
        w_ovf  = w_cur[ACC_W-1];
        w_next = (w_ovf && w_sat) ? '1 : {w_cur[ACC_W-2:0], 1'b0};
      end
      default: begin
        w_next = w_cur;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_ACC; i++) r_acc[i] <= '0;
      r_ovf  <= '0;
      r_view <= VIEW_DATA;
    end else if (w_fire) begin
      for (int i = 0; i < NUM_ACC; i++) begin
        if (w_sel == 2'(i)) begin
          r_acc[i] <= w_next;
          if (w_clr_ovf)  r_ovf[i] <= 1'b0;
          else if (w_ovf) r_ovf[i] <= 1'b1;
        end
      end
      r_view <= (w_op == OP_FLAGS) ? VIEW_FLAGS : VIEW_DATA;
    end
  end

  // High byte is zero-padded above ACC_W
  assign w_hi_shift = w_cur >> 8;
  assign w_flags    = {{(8-NUM_ACC){1'b0}}, r_ovf};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_uo <= 8'h00;
    end else if (r_view == VIEW_FLAGS) begin
      r_uo <= w_flags;
    end else begin
      r_uo <= uio_in[UIO_BYTE] ? w_hi_shift[7:0] : w_cur[7:0];
    end
  end

  assign uo_out  = r_uo;
  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;

endmodule : tt_um_accum_bank
`default_nettype wire

// File: tb/tb_tt_um_accum_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_tt_um_accum_bank
// Purpose  : Self-checking bench for tt_um_accum_bank. Commands update an
//            integer reference model and queue the expected uo_out values
//            with the cycle at which they must appear; a monitor pops and
//            compares them.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_tt_um_accum_bank;
  import tt_accum_pkg::*;

  localparam int ACC_W   = 16;
  localparam int NUM_ACC = 4;
  localparam int MOD     = 1 << ACC_W;
  localparam int MAXU    = MOD - 1;
  localparam int SMAX    = (1 << (ACC_W-1)) - 1;
  localparam int SMIN    = -(1 << (ACC_W-1));

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena = 1'b1;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  tt_um_accum_bank #(
    .ACC_W       (ACC_W),
    .NUM_ACC     (NUM_ACC),
    .SYNC_STAGES (2)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input int id, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s #%0d: got 0x%02h expected 0x%02h (cycle %0d)", name, id, act, exp, cyc);
    end
  endtask

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [7:0] exp;
    int         due;
    int         id;
  } rb_t;

  rb_t sb_q[$];
  int  next_id = 0;

  task automatic push(input logic [7:0] exp, input int due);
    rb_t e;
    e.exp = exp;
    e.due = due;
    e.id  = next_id;
    next_id++;
    sb_q.push_back(e);
  endtask

  always @(negedge clk) begin : monitor
    rb_t e;
    while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
      e = sb_q.pop_front();
      if (e.due < cyc) begin
        n_cmp++;
        n_bad++;
        $display("FAIL readback #%0d missed: due cycle %0d, now %0d", e.id, e.due, cyc);
      end else begin
        check("uo_out", e.id, uo_out, e.exp);
      end
    end
  end

  // ---------------- reference model ----------------
  int              acc_m [NUM_ACC];
  bit [NUM_ACC-1:0] ovf_m;
  bit              flags_m;

  task automatic model_reset();
    for (int i = 0; i < NUM_ACC; i++) acc_m[i] = 0;
    ovf_m   = '0;
    flags_m = 1'b0;
  endtask

  function automatic logic [7:0] model_rb(input int sel, input bit byt);
    if (flags_m) return 8'(ovf_m);
    return byt ? 8'(acc_m[sel] / 256) : 8'(acc_m[sel] % 256);
  endfunction

  task automatic model_exec(input int op, input int sel, input int a, input bit sat);
    int r, s, as;
    case (op)
      1: begin acc_m[sel] = a; ovf_m[sel] = 1'b0; end
      2: begin
        r = acc_m[sel] + a;
        if (r > MAXU) begin ovf_m[sel] = 1'b1; r = sat ? MAXU : r - MOD; end
        acc_m[sel] = r;
      end
      3: begin
        r = acc_m[sel] - a;
        if (r < 0) begin ovf_m[sel] = 1'b1; r = sat ? 0 : r + MOD; end
        acc_m[sel] = r;
      end
      4: begin acc_m[sel] = 0; ovf_m[sel] = 1'b0; end
      5: begin
        s  = (acc_m[sel] > SMAX) ? acc_m[sel] - MOD : acc_m[sel];
        as = (a > 127) ? a - 256 : a;
        r  = s + as;
        if (r > SMAX) begin ovf_m[sel] = 1'b1; if (sat) r = SMAX; end
        else if (r < SMIN) begin ovf_m[sel] = 1'b1; if (sat) r = SMIN; end
        acc_m[sel] = ((r % MOD) + MOD) % MOD;
      end
      6: begin
        r = acc_m[sel] * 2;
        if (r > MAXU) begin ovf_m[sel] = 1'b1; r = sat ? MAXU : r - MOD; end
        acc_m[sel] = r;
      end
      default: ;
    endcase
    flags_m = (op == 7);
  endtask

  // ---------------- stimulus ----------------
  // Strobe raised at negedge of cycle n: old readback due at n+3, new at n+4.
  task automatic cmd(input int op, input int sel, input int a, input bit sat, input bit byt,
                     input int hold = 4);
    int         n;
    logic [7:0] old_e, new_e;
    @(negedge clk);
    old_e = model_rb(sel, byt);
    model_exec(op, sel, a, sat);
    new_e = model_rb(sel, byt);
    n = cyc;
    ui_in  = 8'(a);
    uio_in = {sat, byt, 1'b1, 2'(sel), 3'(op)};
    push(old_e, n + 3);
    push(new_e, n + 4);
    repeat (hold) @(negedge clk);
    uio_in[UIO_STB] = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic rd(input int sel, input bit byt);
    @(negedge clk);
    uio_in = {1'b0, byt, 1'b0, 2'(sel), 3'b000};
    push(model_rb(sel, byt), cyc + 1);
    @(negedge clk);
  endtask

  initial begin
    int op, sel, a, hold, guard;
    bit sat, byt;

    // ---- reset with random pins, strobe high through release ----
    model_reset();
    rst_n  = 1'b0;
    ui_in  = 8'($urandom);
    uio_in = 8'($urandom) | 8'h20;
    repeat (3) @(negedge clk);
    check("reset_uo_out", 0, uo_out, 8'h00);
    check("reset_uio_oe", 0, uio_oe, 8'h00);
    check("reset_uio_out", 0, uio_out, 8'h00);
    ui_in  = 8'hA5;
    uio_in = {1'b0, 1'b0, 1'b1, 2'd0, OP_LOAD};
    rst_n  = 1'b1;
    repeat (6) @(negedge clk);
    uio_in[UIO_STB] = 1'b0;
    repeat (4) @(negedge clk);
    rd(0, 1'b0);
    cmd(7, 0, 0, 1'b0, 1'b0);

    // ---- latency and single execution for a long strobe ----
    cmd(1, 0, 8'h7F, 1'b0, 1'b0);
    cmd(2, 0, 8'h90, 1'b0, 1'b0, 10);
    rd(0, 1'b1);
    rd(0, 1'b0);

    // ---- wrap versus saturate ----
    cmd(4, 1, 0, 1'b0, 1'b0);
    cmd(3, 1, 1, 1'b0, 1'b0);
    rd(1, 1'b1);
    cmd(7, 1, 0, 1'b0, 1'b0);
    cmd(4, 1, 0, 1'b0, 1'b0);
    cmd(3, 1, 1, 1'b1, 1'b0);
    rd(1, 1'b1);
    cmd(7, 1, 0, 1'b0, 1'b0);

    // ---- signed accumulate with and without saturation ----
    cmd(1, 2, 0, 1'b0, 1'b1);
    cmd(5, 2, 8'h80, 1'b1, 1'b1);
    cmd(7, 2, 0, 1'b0, 1'b0);
    for (int i = 0; i < 256; i++) cmd(5, 2, 8'h80, 1'b1, 1'b1, 3);
    rd(2, 1'b0);
    cmd(7, 2, 0, 1'b0, 1'b0);
    cmd(1, 2, 0, 1'b0, 1'b1);
    for (int i = 0; i < 257; i++) cmd(5, 2, 8'h80, 1'b0, 1'b1, 3);
    rd(2, 1'b0);
    cmd(7, 2, 0, 1'b0, 1'b0);

    // ---- shift with carry out ----
    cmd(1, 3, 8'hFF, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) cmd(6, 3, 0, 1'b0, 1'b1);
    rd(3, 1'b0);
    cmd(7, 3, 0, 1'b0, 1'b0);
    cmd(6, 3, 0, 1'b0, 1'b1);
    cmd(7, 3, 0, 1'b0, 1'b0);
    cmd(1, 3, 8'hFF, 1'b0, 1'b0);
    cmd(7, 3, 0, 1'b0, 1'b0);

    // ---- randomized commands ----
    for (int i = 0; i < 80; i++) begin
      op   = $urandom_range(0, 7);
      sel  = $urandom_range(0, NUM_ACC - 1);
      a    = $urandom_range(0, 255);
      sat  = 1'($urandom);
      byt  = 1'($urandom);
      hold = $urandom_range(3, 6);
      cmd(op, sel, a, sat, byt, hold);
      if ($urandom_range(0, 3) == 0) rd($urandom_range(0, NUM_ACC - 1), 1'($urandom));
    end

    // ---- reset in the middle of a command ----
    cmd(1, 0, 8'h3C, 1'b0, 1'b0);
    cmd(1, 1, 8'hC3, 1'b0, 1'b0);
    @(negedge clk);
    ui_in  = 8'h5A;
    uio_in = {1'b0, 1'b0, 1'b1, 2'd1, OP_LOAD};
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midop_reset_uo_out", 0, uo_out, 8'h00);
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    uio_in[UIO_STB] = 1'b0;
    repeat (4) @(negedge clk);
    for (int s = 0; s < NUM_ACC; s++) begin
      rd(s, 1'b0);
      rd(s, 1'b1);
    end
    cmd(7, 0, 0, 1'b0, 1'b0);

    // ---- drain scoreboard with a bound ----
    guard = 0;
    while (sb_q.size() > 0 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (sb_q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d readbacks still pending, required 0", sb_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_tt_um_accum_bank
`default_nettype wire
